// File: rtl/gate_exerciser.sv
// gate_exerciser: drives sw0/sw1 through all four combinations and checks the seven gate outputs against the truth table
module gate_exerciser #(
    parameter int unsigned DWELL = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       sw0,
    output logic       sw1,
    input  logic [6:0] led_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [1:0] step
);
    typedef enum logic [1:0] {S_IDLE, S_DWELL, S_CHECK, S_DONE} state_t;
    localparam logic [31:0] LAST = 32'(DWELL - 1);
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  step_q, step_d;
    logic [6:0]  err_q, err_d, exp_led, diff;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, start_q;
    logic        start_edge;
    assign exp_led    = step_q == 2'd0 ? 7'h59 : step_q == 2'd1 ? 7'h2C : step_q == 2'd2 ? 7'h2D : 7'h46;
    assign diff       = exp_led ^ led_in;
    assign start_edge = start && !start_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start_edge) begin
            state_d = S_DWELL;
            cnt_d   = '0;
            step_d  = '0;
            err_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else if (state_q == S_DWELL) begin
            cnt_d   = cnt_q + 32'd1;
            state_d = cnt_q == LAST ? S_CHECK : S_DWELL;
        end else if (state_q == S_CHECK) begin
            err_d = err_q | diff;
            if (step_q == 2'd3) begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q | diff) == 7'h00;
            end else begin
                state_d = S_DWELL;
                step_d  = step_q + 2'd1;
                cnt_d   = '0;
            end
        end
    end
    // start_q resets high so a start already asserted at reset release is not an edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            start_q <= start;
        end
    end
    assign sw0      = step_q[0];
    assign sw1      = step_q[1];
    assign step     = step_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_mask = err_q;
endmodule
